// File: rtl/ps2_key_sequencer_pkg.sv
// Shared scan-code and ASCII constants, FSM encodings and the letter-case helper
// for the PS/2 key sequencer.
package ps2_key_sequencer_pkg;

   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_LSHIFT   = 8'h12;
   localparam logic [7:0] SC_RSHIFT   = 8'h59;
   localparam logic [7:0] SC_CAPS     = 8'h58;
   localparam logic [7:0] SC_KP_DIV   = 8'h4A;
   localparam logic [7:0] SC_KP_ENTER = 8'h5A;

   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam logic [7:0] ASCII_SLASH    = 8'h2F;
   localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_BRK     = 3'd1;
   localparam logic [2:0] ST_EXT     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
   localparam logic [2:0] ST_LOOKUP  = 3'd4;

   // The translator yields uppercase letters; fold to lowercase unless upper is requested.
   function automatic logic [7:0] apply_case(input logic [7:0] ascii, input logic upper);
      logic [7:0] res;
      res = ascii;
      if (ascii >= 8'h41 && ascii <= 8'h5A && !upper) begin
         res = ascii + ASCII_CASE_OFS;
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_key_sequencer_char_fifo.sv
// Circular character FIFO with a registered head read and a sticky overflow flag.
module ps2_key_sequencer_char_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam logic [PTR_W:0] COUNT_MAX = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [WIDTH-1:0] r_rd_data;
   logic             r_overflow;

   logic             w_do_push;
   logic             w_do_pop;
   logic [PTR_W-1:0] w_rd_ptr_d;
   logic [PTR_W:0]   w_count_d;

   assign full     = (r_count == COUNT_MAX);
   assign empty    = (r_count == '0);
   assign rd_data  = r_rd_data;
   assign overflow = r_overflow;

   // A pop on a full FIFO frees the slot the concurrent push needs.
   assign w_do_pop   = pop && !empty;
   assign w_do_push  = push && (!full || w_do_pop);
   assign w_rd_ptr_d = w_do_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

   always_comb begin
      w_count_d = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_d = r_count + (PTR_W + 1)'(1);
         2'b01:   w_count_d = r_count - (PTR_W + 1)'(1);
         default: w_count_d = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr <= w_rd_ptr_d;
         r_count  <= w_count_d;
         if (push && !w_do_push) begin
            r_overflow <= 1'b1;
         end
         // Head register bypasses the write when the new entry becomes the head.
         if (w_count_d == '0) begin
            r_rd_data <= '0;
         end else if (w_do_push && (r_wr_ptr == w_rd_ptr_d)) begin
            r_rd_data <= push_data;
         end else begin
            r_rd_data <= r_mem[w_rd_ptr_d];
         end
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: prefix/modifier tracking, external translator lookup,
// letter-case folding and a character FIFO toward the terminal.
module ps2_key_sequencer
   import ps2_key_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [7:0] xlat_code,
   input  logic [7:0] xlat_ascii,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       overflow,
   output logic       shift_active,
   output logic       caps_lock
);

   logic [2:0] r_state;
   logic [7:0] r_xlat_code;
   logic       r_shift_l;
   logic       r_shift_r;
   logic       r_caps_lock;
   logic       r_caps_held;

   logic [2:0] w_state_d;
   logic [7:0] w_xlat_d;
   logic       w_shift_l_d;
   logic       w_shift_r_d;
   logic       w_caps_lock_d;
   logic       w_caps_held_d;
   logic       w_push;
   logic [7:0] w_push_data;
   logic       w_full;
   logic       w_empty;

   assign xlat_code    = r_xlat_code;
   assign shift_active = r_shift_l | r_shift_r;
   assign caps_lock    = r_caps_lock;
   assign char_valid   = !w_empty;

   always_comb begin
      w_state_d     = r_state;
      w_xlat_d      = r_xlat_code;
      w_shift_l_d   = r_shift_l;
      w_shift_r_d   = r_shift_r;
      w_caps_lock_d = r_caps_lock;
      w_caps_held_d = r_caps_held;
      w_push        = 1'b0;
      w_push_data   = 8'h00;

      if (r_state == ST_LOOKUP) begin
         w_state_d = ST_IDLE;
         if (xlat_ascii != 8'h00) begin
            w_push      = 1'b1;
            w_push_data = apply_case(xlat_ascii, shift_active ^ r_caps_lock);
         end
      end

      // A byte landing in LOOKUP is decoded as from IDLE so it is not lost.
      if (scan_valid) begin
         case (r_state)
            ST_IDLE, ST_LOOKUP: begin
               case (scan_code)
                  SC_BREAK:  w_state_d = ST_BRK;
                  SC_EXT:    w_state_d = ST_EXT;
                  SC_LSHIFT: w_shift_l_d = 1'b1;
                  SC_RSHIFT: w_shift_r_d = 1'b1;
                  SC_CAPS: begin
                     if (!r_caps_held) begin
                        w_caps_lock_d = ~r_caps_lock;
                     end
                     w_caps_held_d = 1'b1;
                  end
                  default: begin
                     w_xlat_d  = scan_code;
                     w_state_d = ST_LOOKUP;
                  end
               endcase
            end
            ST_BRK: begin
               case (scan_code)
                  SC_LSHIFT: w_shift_l_d   = 1'b0;
                  SC_RSHIFT: w_shift_r_d   = 1'b0;
                  SC_CAPS:   w_caps_held_d = 1'b0;
                  default:   ;
               endcase
               w_state_d = ST_IDLE;
            end
            ST_EXT: begin
               w_state_d = ST_IDLE;
               case (scan_code)
                  SC_BREAK: w_state_d = ST_EXT_BRK;
                  SC_KP_DIV: begin
                     w_push      = 1'b1;
                     w_push_data = ASCII_SLASH;
                  end
                  SC_KP_ENTER: begin
                     w_push      = 1'b1;
                     w_push_data = ASCII_LF;
                  end
                  default: ;
               endcase
            end
            default: w_state_d = ST_IDLE;
         endcase
      end else if (r_state > ST_LOOKUP) begin
         w_state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_xlat_code <= 8'h00;
         r_shift_l   <= 1'b0;
         r_shift_r   <= 1'b0;
         r_caps_lock <= 1'b0;
         r_caps_held <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_xlat_code <= w_xlat_d;
         r_shift_l   <= w_shift_l_d;
         r_shift_r   <= w_shift_r_d;
         r_caps_lock <= w_caps_lock_d;
         r_caps_held <= w_caps_held_d;
      end
   end

   ps2_key_sequencer_char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8),
      .PTR_W (PTR_W)
   ) u_char_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (char_ready),
      .rd_data   (char_data),
      .full      (w_full),
      .empty     (w_empty),
      .overflow  (overflow)
   );

   logic w_unused;
   assign w_unused = w_full;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a small stand-in translator.
module tb_ps2_key_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic [7:0] xlat_code;
   logic [7:0] xlat_ascii;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ready = 1'b1;
   logic       overflow;
   logic       shift_active;
   logic       caps_lock;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   ps2_key_sequencer #(.FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .scan_code    (scan_code),
      .scan_valid   (scan_valid),
      .xlat_code    (xlat_code),
      .xlat_ascii   (xlat_ascii),
      .char_data    (char_data),
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .overflow     (overflow),
      .shift_active (shift_active),
      .caps_lock    (caps_lock)
   );

   always_comb begin
      case (xlat_code)
         8'h1C:   xlat_ascii = 8'h41;
         8'h32:   xlat_ascii = 8'h42;
         8'h16:   xlat_ascii = 8'h31;
         default: xlat_ascii = 8'h00;
      endcase
   end

   // Record every accepted character; sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && char_valid && char_ready) got_q.push_back(char_data);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      scan_code  = b;
      scan_valid = 1'b1;
      @(posedge clk); #1;
      scan_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_q(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1);
      check({tag, "_count"}, 8'(got_q.size()), 8'(n));
      if (n > 0 && got_q.size() > 0) check({tag, "_c0"}, got_q[0], e0);
      if (n > 1 && got_q.size() > 1) check({tag, "_c1"}, got_q[1], e1);
      got_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_xlat"}, xlat_code, 8'h00);
      check({tag, "_valid"}, {7'd0, char_valid}, 8'h00);
      check({tag, "_data"}, char_data, 8'h00);
      check({tag, "_ovf"}, {7'd0, overflow}, 8'h00);
      check({tag, "_shift"}, {7'd0, shift_active}, 8'h00);
      check({tag, "_caps"}, {7'd0, caps_lock}, 8'h00);
   endtask

   initial begin
      idle(3);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      idle(2);

      // Plain make/break: 'a' visible two cycles after the strobe
      send(8'h1C);
      check("lat_n1_valid", {7'd0, char_valid}, 8'h00);
      check("lat_xlat", xlat_code, 8'h1C);
      idle(1);
      check("lat_n2_valid", {7'd0, char_valid}, 8'h01);
      check("lat_n2_data", char_data, 8'h61);
      send(8'hF0); send(8'h1C);
      idle(3);
      expect_q("plain", 1, 8'h61, 8'h00);

      // Shift
      send(8'h12);
      check("shift_on", {7'd0, shift_active}, 8'h01);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      check("shift_off", {7'd0, shift_active}, 8'h00);
      send(8'h1C);
      idle(3);
      expect_q("shift", 2, 8'h41, 8'h61);

      // Caps Lock toggling and typematic repeat
      send(8'h58);
      check("caps_on", {7'd0, caps_lock}, 8'h01);
      send(8'hF0); send(8'h58); send(8'h58);
      check("caps_off", {7'd0, caps_lock}, 8'h00);
      send(8'h58);
      check("caps_repeat", {7'd0, caps_lock}, 8'h00);
      send(8'hF0); send(8'h58); send(8'h1C);
      send(8'h58); send(8'hF0); send(8'h58);
      check("caps_on2", {7'd0, caps_lock}, 8'h01);
      send(8'h12); send(8'h1C);
      idle(3);
      expect_q("caps", 2, 8'h61, 8'h61);
      send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
      check("caps_restore", {7'd0, caps_lock}, 8'h00);

      // Extended keypad keys; arrow discarded
      send(8'hE0); send(8'h4A);
      check("ext_lat_valid", {7'd0, char_valid}, 8'h01);
      check("ext_lat_data", char_data, 8'h2F);
      send(8'hE0); send(8'hF0); send(8'h4A);
      send(8'hE0); send(8'h5A);
      send(8'hE0); send(8'h75);
      idle(3);
      expect_q("ext", 2, 8'h2F, 8'h0A);

      // Byte arriving during LOOKUP is not lost
      @(posedge clk); #1;
      scan_code = 8'h1C; scan_valid = 1'b1;
      @(posedge clk); #1;
      scan_code = 8'h32;
      @(posedge clk); #1;
      scan_valid = 1'b0;
      idle(3);
      expect_q("b2b", 2, 8'h61, 8'h62);

      // Overflow: 10 pushes into 8 entries
      char_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(8'h16);
      idle(2);
      check("ovf_flag", {7'd0, overflow}, 8'h01);
      check("ovf_valid", {7'd0, char_valid}, 8'h01);
      check("ovf_head", char_data, 8'h31);
      char_ready = 1'b1;
      idle(12);
      check("drain_count", 8'(got_q.size()), 8'd8);
      for (int i = 0; i < got_q.size(); i++) check($sformatf("drain_%0d", i), got_q[i], 8'h31);
      got_q.delete();
      check("drain_valid", {7'd0, char_valid}, 8'h00);
      check("drain_data", char_data, 8'h00);
      check("ovf_sticky", {7'd0, overflow}, 8'h01);

      // Reset mid-sequence discards the F0 prefix
      send(8'h12);
      send(8'hF0);
      rst_n = 1'b0;
      idle(2);
      check_reset_outputs("rst_mid");
      rst_n = 1'b1;
      idle(1);
      send(8'h1C);
      idle(3);
      expect_q("after_rst", 1, 8'h61, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Sequences PS/2 scan-code bytes from the PS/2 receiver through the existing combinational scan-code-to-ASCII translator. Tracks prefixes (E0 extended, F0 break), Shift and Caps Lock state, and applies case to letters. Handles extended keypad keys locally. Buffers the resulting ASCII characters in a small FIFO with a valid/ready interface to the terminal logic.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; must be a power of 2 and at least 2.
PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width. Derived; not overridden.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_code  in  8  byte from PS/2 receiver
scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
xlat_code  out  8  registered code driven to the translator input
xlat_ascii  in  8  translator output; combinational from xlat_code, 0x00 = no character
char_data  out  8  FIFO head character
char_valid  out  1  FIFO not empty
char_ready  in  1  consumer accepts char_data when char_valid && char_ready
overflow  out  1  sticky; a character was dropped because the FIFO was full
shift_active  out  1  left or right Shift held
caps_lock  out  1  Caps Lock toggle state

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears the following: FSM=IDLE, xlat_code=0x00, FIFO empty (char_valid=0, char_data=0x00), overflow=0, shift_l=shift_r=0, caps_lock=0, caps_held=0.
- FSM states: IDLE, BRK, EXT, EXT_BRK, LOOKUP. Only scan_valid cycles advance states other than LOOKUP.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - 12 -> set shift_l, stay in IDLE.
  - 59 -> set shift_r, stay in IDLE.
  - 58 -> if !caps_held, toggle caps_lock; set caps_held. Stay in IDLE.
  - Any other byte -> xlat_code<=byte, go to LOOKUP.
- BRK: the next byte is a release.
  - 12 clears shift_l.
  - 59 clears shift_r.
  - 58 clears caps_held.
  - Other bytes are ignored. Return to IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - 4A -> push 0x2F, then IDLE.
  - 5A -> push 0x0A, then IDLE.
  - Any other byte is discarded (arrows etc.), then IDLE.
- EXT_BRK: consume one byte with no action, then IDLE.
- LOOKUP: lasts exactly one cycle and samples xlat_ascii.
  - 0x00 is dropped.
  - 0x41..0x5A: pushed unchanged if (shift_active XOR caps_lock), else pushed +0x20 (lowercase).
  - Other values are pushed unchanged.
  - Return to IDLE.
- A scan_valid arriving while in LOOKUP is processed as if in IDLE in that same cycle. The PS/2 byte rate makes this rare, but it must not be lost.
- Latency: make code on scan_valid at cycle N -> push at the clock edge ending cycle N+1 -> char_valid high in cycle N+2. Extended keypad push: char_valid in cycle N+1.
- Typematic repeats (repeated make codes with no F0) each produce a character. A Caps Lock repeat does not re-toggle.
- FIFO is circular with PTR_W-bit pointers plus a count of width PTR_W+1. Pointers wrap from FIFO_DEPTH-1 to 0.
  - Push when full: data is dropped, overflow<=1 (sticky until reset), pointers and count unchanged.
  - Pop when empty: no effect.
  - Simultaneous push and pop when full: the pop frees a slot and the push is accepted. Count unchanged, overflow not set.
  - Simultaneous push and pop when empty: the push is stored, the pop does nothing (char_valid was 0).
- char_data comes from a registered read of the FIFO head. It is 0x00 when empty.
- shift_active = shift_l | shift_r.
- Reset mid-sequence (for example after F0 is received) discards the pending prefix.

Decomposition:
- Shared package/header (the existing header include) holds:
  - scan constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_KP_DIV=4A, SC_KP_ENTER=5A;
  - ASCII constants: ASCII_LF=0A, ASCII_SLASH=2F, ASCII_CASE_OFS=20;
  - the FSM state encodings.
- Sub-module char_fifo (parameterised DEPTH/WIDTH=8, with push/pop/full/empty/overflow) is instantiated once.
- The translator stays external and is wired at the top level via xlat_code/xlat_ascii.

Test Plan:
- Bytes 1C, F0 1C with no modifiers -> one char 0x61 ('a'), valid 2 cycles after the 1C strobe. The F0 1C pair produces nothing.
- 12, 1C, F0 1C, F0 12, 1C -> chars 0x41 then 0x61; shift_active goes 1 then 0.
- 58, F0 58, 58, 58 (repeat), F0 58, 1C -> caps_lock goes 1 then 0 (the repeat does not toggle) -> char 0x61. Also 58, F0 58, 12, 1C -> 0x61 (Shift XOR Caps).
- E0 4A, E0 F0 4A, E0 5A, E0 75 -> chars 0x2F, 0x0A only; the arrow key is discarded.
- char_ready=0, 10 make codes of 16 (digit '1') with FIFO_DEPTH=8 -> 8 entries of 0x31, overflow=1. Then drain with char_ready=1 -> exactly 8 pops, char_valid=0.
- rst_n pulsed low after F0 is sent, then 1C -> char 0x61 appears (the prefix was cleared); all outputs are at reset values while rst_n is low.
